// File: rtl/countdown_modulo_k.sv
// countdown_modulo_k: modulo-K down counter with IDLE/RUN/DONE control FSM.
// The count can be preset in IDLE (saturated to K-1). Once started it
// decrements on each enabled cycle and finishes with a one-cycle done pulse.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN. When defined, the terminal
// event reloads the stored preset and keeps counting instead of going to DONE.
// Reset aclr is asynchronous and active-low.
module countdown_modulo_k #(
  parameter  int unsigned K = 10,
  localparam int unsigned N = (K > 2) ? $clog2(K) : 1
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  output logic [N-1:0] Q,
  output logic         borrow,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] KM1  = N'(K - 1);
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = N'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_q;
  logic [N-1:0] w_q_nxt;
  logic         r_done;
  logic         w_done_nxt;
  logic [N-1:0] w_load_sat;
  logic         w_q_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [N-1:0] r_reload;
  logic [N-1:0] w_reload_nxt;
`endif

  // Presets above the modulus clamp to the largest legal count.
  assign w_load_sat = (32'(load_val) > (K - 1)) ? KM1 : load_val;
  assign w_q_zero   = (r_q == ZERO);

  // State, count and done pulse registers; reset forces an idle, zeroed block.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state <= S_IDLE;
      r_q     <= ZERO;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Stored reload value, written only by an IDLE preset.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) r_reload <= KM1;
    else       r_reload <= w_reload_nxt;
  end
`endif

  // Next-state, next-count and done-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    w_reload_nxt = r_reload;
`endif
    case (r_state)
      S_IDLE: begin
        // load and start may coincide: preset lands on the same edge RUN begins.
        if (load) begin
          w_q_nxt = w_load_sat;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          w_reload_nxt = w_load_sat;
`endif
        end
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // stop wins over enable and leaves the count where it is.
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (enable) begin
          if (!w_q_zero) begin
            w_q_nxt = r_q - ONE;
          end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            w_q_nxt    = r_reload;
            w_done_nxt = 1'b1;
`else
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
`endif
          end
        end
      end
      S_DONE: begin
        // One-cycle terminal state; done is high exactly while here.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign Q      = r_q;
  assign borrow = w_q_zero;
  assign busy   = (r_state == S_RUN);
  assign done   = r_done;

endmodule

// File: tb/tb_countdown_modulo_k.sv
// Directed bench for countdown_modulo_k at K = 10, default build.
module tb_countdown_modulo_k;

  localparam int N = 4;

  logic         clk;
  logic         aclr;
  logic         enable;
  logic         load;
  logic [N-1:0] load_val;
  logic         start;
  logic         stop;
  logic [N-1:0] Q;
  logic         borrow;
  logic         busy;
  logic         done;

  int checks;
  int errors;

  countdown_modulo_k #(.K(10)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .enable   (enable),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .Q        (Q),
    .borrow   (borrow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eq, input int eborrow,
                         input int ebusy, input int edone);
    chk({tag, ".Q"},      32'(Q),      32'(eq));
    chk({tag, ".borrow"}, 32'(borrow), 32'(eborrow));
    chk({tag, ".busy"},   32'(busy),   32'(ebusy));
    chk({tag, ".done"},   32'(done),   32'(edone));
  endtask

  initial begin
    checks = 0; errors = 0;
    enable = 0; load = 0; load_val = '0; start = 0; stop = 0;
    aclr = 1'b1;
    #1 aclr = 1'b0;
    #7;
    chk_all("reset", 0, 1, 0, 0);
    aclr = 1'b1;
    tick();

    // Idle with Q=0 and enable high: nothing moves, no done.
    enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("idle_en", 0, 1, 0, 0);
    end
    enable = 0;

    // Load 7, start, count to zero; done 8 cycles after RUN entry.
    load = 1; load_val = 4'd7;
    tick();
    chk_all("load7", 7, 0, 0, 0);
    load = 0; start = 1; enable = 1;
    tick();
    chk_all("run7_entry", 7, 0, 1, 0);
    start = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_all("run7_cnt", 7 - i, (i == 7) ? 1 : 0, 1, 0);
    end
    tick();
    chk_all("run7_done", 0, 1, 0, 1);
    tick();
    chk_all("run7_after", 0, 1, 0, 0);
    enable = 0;

    // Preset 13 saturates to 9; enable every other cycle -> done on clock 20.
    load = 1; load_val = 4'd13;
    tick();
    chk_all("sat13", 9, 0, 0, 0);
    load = 0; start = 1;
    tick();
    chk_all("run9_entry", 9, 0, 1, 0);
    start = 0;
    for (int c = 1; c <= 20; c++) begin
      enable = (c % 2 == 0);
      tick();
      if (c < 20)
        chk_all("run9_cnt", (c / 2 > 9) ? 0 : 9 - c / 2, (c >= 18) ? 1 : 0, 1, 0);
      else
        chk_all("run9_done", 0, 1, 0, 1);
    end
    enable = 0;
    tick();
    chk_all("run9_after", 0, 1, 0, 0);

    // Exact K-1 preset is kept as is.
    load = 1; load_val = 4'd9;
    tick();
    chk_all("load9", 9, 0, 0, 0);

    // load+start on the same edge, then stop with enable at Q=4.
    load = 1; load_val = 4'd6; start = 1;
    tick();
    chk_all("ldst6", 6, 0, 1, 0);
    load = 0; start = 0; enable = 1;
    tick();
    chk_all("run6_a", 5, 0, 1, 0);
    tick();
    chk_all("run6_b", 4, 0, 1, 0);
    stop = 1;
    tick();
    chk_all("stop4", 4, 0, 0, 0);
    stop = 0;
    tick();
    chk_all("idle4_en", 4, 0, 0, 0);
    start = 1;
    tick();
    chk_all("resume4", 4, 0, 1, 0);
    start = 0; load = 1; load_val = 4'd1;
    tick();
    chk_all("run_ld_ign", 3, 0, 1, 0);
    load = 0; enable = 0;
    tick();
    chk_all("run_hold3", 3, 0, 1, 0);

    // Asynchronous reset mid-cycle while running at Q=3.
    #3 aclr = 1'b0;
    #1;
    chk_all("aclr_mid", 0, 1, 0, 0);
    #1 aclr = 1'b1;
    enable = 1;
    tick();
    chk_all("post_aclr", 0, 1, 0, 0);
    tick();
    chk_all("post_aclr2", 0, 1, 0, 0);

    // Start from Q=0 finishes on the first enabled cycle.
    start = 1;
    tick();
    chk_all("st0_entry", 0, 1, 1, 0);
    start = 0;
    tick();
    chk_all("st0_done", 0, 1, 0, 1);
    tick();
    chk_all("st0_after", 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_modulo_k.md
COUNTDOWN_MODULO_K -- requirements
Module: countdown_modulo_k

Interface
REQ-001 Parameter K, default 10, SHALL set the modulus; legal range 2..2^16.
REQ-002 Local width N SHALL be the minimum bits to hold K-1, never less than 1.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 aclr  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  count tick; one decrement per cycle while high in RUN.
REQ-006 load  input  1  synchronous preset request, honoured only in IDLE.
REQ-007 load_val  input  N  preset value.
REQ-008 start  input  1  begin countdown.
REQ-009 stop  input  1  abort countdown.
REQ-010 Q  output  N  current count (registered).
REQ-011 borrow  output  1  combinational, high whenever Q == 0 (cascade output).
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  registered single-cycle terminal pulse.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE + load: Q SHALL take load_val next edge; load_val > K-1 SHALL saturate to K-1; the stored reload value SHALL take the same value.
REQ-016 IDLE + start: next state RUN; load and start together SHALL apply the load and enter RUN on the same edge.
REQ-017 IDLE without start: Q SHALL hold; enable SHALL be ignored.
REQ-018 RUN + enable + Q > 0: Q SHALL decrement by exactly 1 (modulo-N arithmetic, no wrap).
REQ-019 RUN + enable + Q == 0: terminal event; next state DONE, Q stays 0 (see REQ-028 for the macro variant).
REQ-020 RUN + !enable: Q SHALL hold; state stays RUN.
REQ-021 RUN + stop: next state IDLE, Q SHALL hold its current value, no done pulse; stop SHALL take priority over enable in the same cycle.
REQ-022 RUN: load and start SHALL be ignored.
REQ-023 DONE: done SHALL be 1 for exactly that one cycle; next state IDLE unconditionally; inputs ignored.
REQ-024 start in IDLE with Q == 0 SHALL enter RUN and reach DONE on the first enable cycle.
REQ-025 Latency: from the edge entering RUN with Q = v, done SHALL assert after exactly v+1 enabled cycles.

Reset
REQ-026 aclr low SHALL immediately force state IDLE, Q = 0, reload value = K-1, done = 0, busy = 0; borrow therefore 1.
REQ-027 Reset mid-RUN SHALL abandon the countdown with no done pulse; after release the block SHALL wait in IDLE.

Configuration
REQ-028 Macro COUNTDOWN_AUTO_RELOAD_EN defined: at the terminal event (REQ-019) done SHALL pulse high in the same cycle the state stays RUN and Q reloads the stored reload value; countdown repeats until stop or reset.
REQ-029 Macro COUNTDOWN_AUTO_RELOAD_EN undefined: reload register SHALL NOT be built; DONE state behaviour per REQ-019/023 applies; start always counts from current Q.

Verification (K = 10)
REQ-030 Reset, then load=1 load_val=7, then start, enable held high -> Q 7,6,...,0; done pulses once exactly 8 cycles after RUN entry; busy low after.
REQ-031 IDLE, load_val=13 -> Q saturates to 9; borrow=0; start with enable toggled every other cycle -> done after 10 enabled cycles (20 clocks).
REQ-032 RUN at Q=4, stop and enable both high -> Q holds 4, state IDLE, no done; subsequent start resumes from 4.
REQ-033 RUN at Q=3, aclr pulsed low mid-cycle -> Q=0, busy=0, borrow=1 immediately, no done pulse.
REQ-034 COUNTDOWN_AUTO_RELOAD_EN defined, load 2, start, enable high -> Q 2,1,0,2,1,0...; done high on every Q=0 enabled cycle, busy stays 1.
REQ-035 IDLE with Q=0, enable high, no start -> Q stays 0, done never asserts.
